// File: rtl/bm_arbiter.sv
// bm_arbiter: shares the single VRAM/register bus-master port between the 6502 (port A, buffered strobes)
// and a DMA/blitter (port B, req/ack), with a starvation guard and in-order read data routing.
module bm_arbiter #(
    parameter int A_DEPTH     = 2,
    parameter int OUTSTANDING = 4,
    parameter int MAX_WAIT    = 8
) (
    input  logic        bm_clk,
    input  logic        bm_reset,
    input  logic        a_strobe,
    input  logic        a_write,
    input  logic [18:0] a_addr,
    input  logic [7:0]  a_wrdata,
    output logic [7:0]  a_rddata,
    output logic        a_rdvalid,
    output logic        a_overflow,
    input  logic        a_overflow_clr,
    input  logic        b_req,
    input  logic        b_write,
    input  logic [18:0] b_addr,
    input  logic [7:0]  b_wrdata,
    output logic        b_ack,
    output logic [7:0]  b_rddata,
    output logic        b_rdvalid,
    output logic        s_strobe,
    output logic        s_write,
    output logic [18:0] s_addr,
    output logic [7:0]  s_wrdata,
    input  logic        s_ready,
    input  logic        s_rdvalid,
    input  logic [7:0]  s_rddata
);
    localparam int AW  = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
    localparam int ACW = $clog2(A_DEPTH + 1);
    localparam int TW  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int TCW = $clog2(OUTSTANDING + 1);

    logic [27:0]    a_mem_q [A_DEPTH];
    logic [27:0]    a_mem_d [A_DEPTH];
    logic [AW-1:0]  a_wp_q, a_wp_d, a_rp_q, a_rp_d;
    logic [ACW-1:0] a_cnt_q, a_cnt_d;
    logic           a_overflow_q, a_overflow_d;
    logic           tag_mem_q [OUTSTANDING];
    logic           tag_mem_d [OUTSTANDING];
    logic [TW-1:0]  tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
    logic [TCW-1:0] tag_cnt_q, tag_cnt_d;
    logic [7:0]     wait_q, wait_d;
    logic           s_strobe_q, s_strobe_d, s_write_q, s_write_d, s_port_q, s_port_d;
    logic [18:0]    s_addr_q, s_addr_d;
    logic [7:0]     s_wrdata_q, s_wrdata_d;
    logic           b_ack_q, b_ack_d;
    logic           a_rdvalid_q, a_rdvalid_d, b_rdvalid_q, b_rdvalid_d;
    logic [7:0]     a_rddata_q, a_rddata_d, b_rddata_q, b_rddata_d;

    logic [27:0] a_in, a_head;
    logic        slot_free, tag_push, tag_pop, rd_ok, a_ok, b_ok, grant_a, grant_b, a_push;

    always_comb begin
        a_in      = {a_write, a_addr, a_wrdata};
        // An empty FIFO is bypassed so a strobe can reach s_* on the very next edge.
        a_head    = (a_cnt_q == '0) ? a_in : a_mem_q[a_rp_q];
        slot_free = !s_strobe_q || s_ready;
        tag_push  = s_strobe_q && s_ready && !s_write_q;
        tag_pop   = s_rdvalid && (tag_cnt_q != '0);
        rd_ok     = ({1'b0, tag_cnt_q} + {{TCW{1'b0}}, tag_push} - {{TCW{1'b0}}, tag_pop})
                    < (TCW+1)'(OUTSTANDING);
        a_ok      = ((a_cnt_q != '0) || a_strobe) && (a_head[27] || rd_ok);
        // b_req is still high during the ack cycle; masking it prevents a double grant.
        b_ok      = b_req && !b_ack_q && (b_write || rd_ok);
        grant_b   = slot_free && b_ok && ((wait_q == 8'(MAX_WAIT)) || !a_ok);
        grant_a   = slot_free && a_ok && !grant_b;
        a_push    = a_strobe && ((a_cnt_q != ACW'(A_DEPTH)) || grant_a);
        a_mem_d   = a_mem_q;
        if (a_push)
            a_mem_d[a_wp_q] = a_in;
        a_wp_d       = !a_push ? a_wp_q : (a_wp_q == AW'(A_DEPTH - 1)) ? '0 : a_wp_q + AW'(1);
        a_rp_d       = !grant_a ? a_rp_q : (a_rp_q == AW'(A_DEPTH - 1)) ? '0 : a_rp_q + AW'(1);
        a_cnt_d      = a_cnt_q + ACW'(a_push) - ACW'(grant_a);
        a_overflow_d = (a_overflow_q && !a_overflow_clr) || (a_strobe && !a_push);
        tag_mem_d    = tag_mem_q;
        if (tag_push)
            tag_mem_d[tag_wp_q] = s_port_q;
        tag_wp_d  = !tag_push ? tag_wp_q : (tag_wp_q == TW'(OUTSTANDING - 1)) ? '0 : tag_wp_q + TW'(1);
        tag_rp_d  = !tag_pop ? tag_rp_q : (tag_rp_q == TW'(OUTSTANDING - 1)) ? '0 : tag_rp_q + TW'(1);
        tag_cnt_d = tag_cnt_q + TCW'(tag_push) - TCW'(tag_pop);
        wait_d    = (!b_req || grant_b || b_ack_q) ? 8'd0 :
                    (wait_q == 8'(MAX_WAIT)) ? wait_q : wait_q + 8'd1;
        s_strobe_d  = slot_free ? (grant_a || grant_b) : s_strobe_q;
        s_write_d   = grant_b ? b_write  : grant_a ? a_head[27]   : s_write_q;
        s_addr_d    = grant_b ? b_addr   : grant_a ? a_head[26:8] : s_addr_q;
        s_wrdata_d  = grant_b ? b_wrdata : grant_a ? a_head[7:0]  : s_wrdata_q;
        s_port_d    = grant_b ? 1'b1     : grant_a ? 1'b0         : s_port_q;
        b_ack_d     = grant_b;
        a_rdvalid_d = tag_pop && !tag_mem_q[tag_rp_q];
        b_rdvalid_d = tag_pop && tag_mem_q[tag_rp_q];
        a_rddata_d  = a_rdvalid_d ? s_rddata : a_rddata_q;
        b_rddata_d  = b_rdvalid_d ? s_rddata : b_rddata_q;
    end

    always_ff @(posedge bm_clk or posedge bm_reset) begin
        if (bm_reset) begin
            a_mem_q      <= '{default: '0};
            a_wp_q       <= '0;
            a_rp_q       <= '0;
            a_cnt_q      <= '0;
            a_overflow_q <= 1'b0;
            tag_mem_q    <= '{default: 1'b0};
            tag_wp_q     <= '0;
            tag_rp_q     <= '0;
            tag_cnt_q    <= '0;
            wait_q       <= '0;
            s_strobe_q   <= 1'b0;
            s_write_q    <= 1'b0;
            s_addr_q     <= '0;
            s_wrdata_q   <= '0;
            s_port_q     <= 1'b0;
            b_ack_q      <= 1'b0;
            a_rdvalid_q  <= 1'b0;
            b_rdvalid_q  <= 1'b0;
            a_rddata_q   <= '0;
            b_rddata_q   <= '0;
        end else begin
            a_mem_q      <= a_mem_d;
            a_wp_q       <= a_wp_d;
            a_rp_q       <= a_rp_d;
            a_cnt_q      <= a_cnt_d;
            a_overflow_q <= a_overflow_d;
            tag_mem_q    <= tag_mem_d;
            tag_wp_q     <= tag_wp_d;
            tag_rp_q     <= tag_rp_d;
            tag_cnt_q    <= tag_cnt_d;
            wait_q       <= wait_d;
            s_strobe_q   <= s_strobe_d;
            s_write_q    <= s_write_d;
            s_addr_q     <= s_addr_d;
            s_wrdata_q   <= s_wrdata_d;
            s_port_q     <= s_port_d;
            b_ack_q      <= b_ack_d;
            a_rdvalid_q  <= a_rdvalid_d;
            b_rdvalid_q  <= b_rdvalid_d;
            a_rddata_q   <= a_rddata_d;
            b_rddata_q   <= b_rddata_d;
        end
    end

    assign a_rddata   = a_rddata_q;
    assign a_rdvalid  = a_rdvalid_q;
    assign a_overflow = a_overflow_q;
    assign b_ack      = b_ack_q;
    assign b_rddata   = b_rddata_q;
    assign b_rdvalid  = b_rdvalid_q;
    assign s_strobe   = s_strobe_q;
    assign s_write    = s_write_q;
    assign s_addr     = s_addr_q;
    assign s_wrdata   = s_wrdata_q;
endmodule
